pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, rally count, scoring and game-over.
// All outputs come straight from registers so the video mux sees no glitches.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       hit,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       gra_still,
  output logic       ball_launch,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [7:0] rally,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] LP_SERVE = 8'(SERVE_TICKS);
  localparam logic [7:0] LP_OVER  = 8'(OVER_TICKS);
  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_rally;
  logic [3:0] r_score1;
  logic [3:0] r_score2;
  logic [1:0] r_winner;
  logic       r_serve_dir;
  logic       r_launch;
  logic       r_gra_still;
  logic       r_any_prev;
  logic       r_b1_prev;
  logic       r_b2_prev;

  logic w_any;
  logic w_b1;
  logic w_b2;
  logic w_btn_edge;
  logic w_serve_edge;
  logic w_expired;

  assign w_any        = w_b1 | w_b2;
  assign w_b1         = |btn1;
  assign w_b2         = |btn2;
  assign w_btn_edge   = w_any & ~r_any_prev;
  assign w_serve_edge = r_serve_dir ? (w_b2 & ~r_b2_prev)
                                    : (w_b1 & ~r_b1_prev);
  assign w_expired    = (r_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_rally     <= 8'd0;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_winner    <= 2'b00;
      r_serve_dir <= 1'b0;
      r_launch    <= 1'b0;
      r_gra_still <= 1'b1;
      r_any_prev  <= 1'b0;
      r_b1_prev   <= 1'b0;
      r_b2_prev   <= 1'b0;
    end else begin
      r_any_prev <= w_any;
      r_b1_prev  <= w_b1;
      r_b2_prev  <= w_b2;
      r_launch   <= 1'b0;
      // state-entry loads below override this decrement
      if (frame_tick && !w_expired)
        r_cnt <= r_cnt - 8'd1;
      unique case (r_state)
        S_IDLE: begin
          if (w_btn_edge) begin
            r_state     <= S_SERVE;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_winner    <= 2'b00;
            r_rally     <= 8'd0;
            r_serve_dir <= 1'b0;
            r_cnt       <= LP_SERVE;
          end
        end
        S_SERVE: begin
          if (w_expired && w_serve_edge) begin
            r_state     <= S_PLAY;
            r_launch    <= 1'b1;
            r_gra_still <= 1'b0;
          end
        end
        S_PLAY: begin
          if (miss_left || miss_right) begin
            r_state     <= S_POINT;
            r_cnt       <= LP_SERVE;
            r_gra_still <= 1'b1;
            if (miss_left && !miss_right) begin
              r_serve_dir <= 1'b0;
              if (r_score2 < LP_WIN)
                r_score2 <= r_score2 + 4'd1;
            end else if (miss_right && !miss_left) begin
              r_serve_dir <= 1'b1;
              if (r_score1 < LP_WIN)
                r_score1 <= r_score1 + 4'd1;
            end
          end else if (hit && r_rally != 8'hFF) begin
            r_rally <= r_rally + 8'd1;
          end
        end
        S_POINT: begin
          if (w_expired) begin
            if (r_score1 == LP_WIN) begin
              r_state  <= S_OVER;
              r_winner <= 2'b01;
              r_cnt    <= LP_OVER;
            end else if (r_score2 == LP_WIN) begin
              r_state  <= S_OVER;
              r_winner <= 2'b10;
              r_cnt    <= LP_OVER;
            end else begin
              r_state <= S_SERVE;
              r_cnt   <= LP_SERVE;
              r_rally <= 8'd0;
            end
          end
        end
        S_OVER: begin
          if (w_expired)
            r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gra_still <= 1'b1;
        end
      endcase
    end
  end

  assign gra_still   = r_gra_still;
  assign ball_launch = r_launch;
  assign serve_dir   = r_serve_dir;
  assign score1      = r_score1;
  assign score2      = r_score2;
  assign winner      = r_winner;
  assign rally       = r_rally;
  assign state       = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: a default-parameter unit plus a
// WIN_SCORE=2 unit share the same stimulus; expectations go through a queue.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] btn1 = 2'b00;
  logic [1:0] btn2 = 2'b00;
  logic       hit = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;

  logic       a_gra, a_launch, a_sd;
  logic [3:0] a_s1, a_s2;
  logic [1:0] a_win;
  logic [7:0] a_rally;
  logic [2:0] a_state;
  logic       b_gra, b_launch, b_sd;
  logic [3:0] b_s1, b_s2;
  logic [1:0] b_win;
  logic [7:0] b_rally;
  logic [2:0] b_state;

  pong_match_ctrl u_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn1(btn1), .btn2(btn2), .hit(hit),
    .miss_left(miss_left), .miss_right(miss_right),
    .gra_still(a_gra), .ball_launch(a_launch), .serve_dir(a_sd),
    .score1(a_s1), .score2(a_s2), .winner(a_win),
    .rally(a_rally), .state(a_state)
  );

  pong_match_ctrl #(.WIN_SCORE(2)) u_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn1(btn1), .btn2(btn2), .hit(hit),
    .miss_left(miss_left), .miss_right(miss_right),
    .gra_still(b_gra), .ball_launch(b_launch), .serve_dir(b_sd),
    .score1(b_s1), .score2(b_s2), .winner(b_win),
    .rally(b_rally), .state(b_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int sel, st, s1, s2, w, r, sd, gs, bl;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string tag, string f, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, f, obs, exp);
    end
  endtask

  task automatic ex(int sel, string tag, int st, int s1, int s2,
                    int w, int r, int sd, int gs, int bl);
    exp_t e;
    e.tag = tag; e.sel = sel; e.st = st; e.s1 = s1; e.s2 = s2;
    e.w = w; e.r = r; e.sd = sd; e.gs = gs; e.bl = bl;
    q.push_back(e);
  endtask

  task automatic cmp();
    exp_t e;
    e = q.pop_front();
    if (e.sel == 0) begin
      chk(e.tag, "state", int'(a_state), e.st);
      chk(e.tag, "score1", int'(a_s1), e.s1);
      chk(e.tag, "score2", int'(a_s2), e.s2);
      chk(e.tag, "winner", int'(a_win), e.w);
      chk(e.tag, "rally", int'(a_rally), e.r);
      chk(e.tag, "serve_dir", int'(a_sd), e.sd);
      chk(e.tag, "gra_still", int'(a_gra), e.gs);
      chk(e.tag, "ball_launch", int'(a_launch), e.bl);
    end else begin
      chk(e.tag, "state", int'(b_state), e.st);
      chk(e.tag, "score1", int'(b_s1), e.s1);
      chk(e.tag, "score2", int'(b_s2), e.s2);
      chk(e.tag, "winner", int'(b_win), e.w);
      chk(e.tag, "rally", int'(b_rally), e.r);
      chk(e.tag, "serve_dir", int'(b_sd), e.sd);
      chk(e.tag, "gra_still", int'(b_gra), e.gs);
      chk(e.tag, "ball_launch", int'(b_launch), e.bl);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic rel();
    btn1 = 2'b00;
    btn2 = 2'b00;
    step();
  endtask

  task automatic hit_pulse();
    hit = 1'b1; step();
    hit = 1'b0; step();
  endtask

  initial begin
    repeat (2) step();
    ex(0, "rst", 0, 0, 0, 0, 0, 0, 1, 0); cmp();
    ex(1, "rst_b", 0, 0, 0, 0, 0, 0, 1, 0); cmp();
    reset = 1'b1; step();

    ex(0, "idle_go", 1, 0, 0, 0, 0, 0, 1, 0);
    btn2 = 2'b01; step(); cmp(); rel();

    ex(0, "early", 1, 0, 0, 0, 0, 0, 1, 0);
    tick(10); btn2 = 2'b10; step(); rel();
    tick(109); btn1 = 2'b01; step(); cmp(); rel();

    ex(0, "launch", 2, 0, 0, 0, 0, 0, 0, 1);
    tick(1); btn1 = 2'b01; step(); cmp();
    ex(0, "launch_end", 2, 0, 0, 0, 0, 0, 0, 0);
    rel(); cmp();

    ex(0, "miss_r", 3, 1, 0, 0, 3, 1, 1, 0);
    repeat (3) hit_pulse();
    miss_right = 1'b1; step(); miss_right = 1'b0; cmp();

    ex(0, "point_hold", 3, 1, 0, 0, 3, 1, 1, 0);
    tick(60);
    hit = 1'b1; miss_left = 1'b1; step();
    hit = 1'b0; miss_left = 1'b0;
    tick(59); cmp();
    ex(0, "point_exp", 1, 1, 0, 0, 0, 1, 1, 0);
    tick(1); cmp();

    ex(0, "serve2", 2, 1, 0, 0, 0, 1, 0, 1);
    tick(120); btn2 = 2'b01; step(); cmp(); rel();

    ex(0, "both_miss", 3, 1, 0, 0, 0, 1, 1, 0);
    miss_left = 1'b1; miss_right = 1'b1; step();
    miss_left = 1'b0; miss_right = 1'b0; cmp();

    ex(0, "serve3", 2, 1, 0, 0, 0, 1, 0, 1);
    tick(120); tick(120); btn2 = 2'b01; step(); cmp(); rel();

    ex(0, "hit_miss", 3, 1, 1, 0, 1, 0, 1, 0);
    hit_pulse();
    hit = 1'b1; miss_left = 1'b1; step();
    hit = 1'b0; miss_left = 1'b0; cmp();

    ex(0, "serve4", 2, 1, 1, 0, 0, 0, 0, 1);
    tick(120); tick(120); btn1 = 2'b10; step(); cmp(); rel();

    ex(0, "sat", 2, 1, 1, 0, 255, 0, 0, 0);
    repeat (300) hit_pulse();
    cmp();

    ex(0, "pt_a", 3, 1, 2, 0, 255, 0, 1, 0);
    ex(1, "pt_b", 3, 1, 2, 0, 255, 0, 1, 0);
    miss_left = 1'b1; step(); miss_left = 1'b0;
    cmp(); cmp();

    ex(0, "a_cont", 1, 1, 2, 0, 0, 0, 1, 0);
    ex(1, "b_over", 4, 1, 2, 2, 255, 0, 1, 0);
    tick(120); cmp(); cmp();

    ex(1, "over_hold", 4, 1, 2, 2, 255, 0, 1, 0);
    tick(90); btn1 = 2'b01; step(); rel();
    tick(89); cmp();
    ex(1, "over_exp", 0, 1, 2, 2, 255, 0, 1, 0);
    tick(1); cmp();
    ex(1, "restart", 1, 0, 0, 0, 0, 0, 1, 0);
    btn2 = 2'b01; step(); cmp(); rel();

    reset = 1'b0; step();
    reset = 1'b1; step();
    btn2 = 2'b01; step(); rel();
    tick(120); btn1 = 2'b01; step(); rel();
    repeat (3) begin
      miss_right = 1'b1; step(); miss_right = 1'b0; step();
      tick(120); tick(120);
      btn2 = 2'b01; step(); rel();
    end
    ex(0, "pre_rst", 2, 3, 0, 0, 0, 1, 0, 0); cmp();

    ex(0, "async_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    btn1 = 2'b01; reset = 1'b0; #2; cmp();

    ex(0, "held_edge", 1, 0, 0, 0, 0, 0, 1, 0);
    step(); reset = 1'b1; step(); cmp();
    ex(0, "no_reedge", 1, 0, 0, 0, 0, 0, 1, 0);
    step(); step(); cmp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
